// File: rtl/scan_test_controller.sv
// Scan test sequencer: loads a pattern, runs functional capture cycles,
// then unloads the chain and compares the response against an expected vector.
module scan_test_controller #(
    parameter int CHAIN_LEN  = 4,
    parameter int CAP_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [CHAIN_LEN-1:0]           pattern,
    input  logic [CHAIN_LEN-1:0]           expected,
    input  logic                           scan_out,
    output logic                           scan_en,
    output logic                           scan_in,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [$clog2(CHAIN_LEN+1)-1:0] mismatch_cnt
);

    localparam int MW   = $clog2(CHAIN_LEN + 1);
    localparam int CMAX = (CHAIN_LEN > CAP_CYCLES) ? CHAIN_LEN : CAP_CYCLES;
    localparam int CW   = $clog2(CMAX);

    localparam logic [CW-1:0] LOAD_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CAP_LAST  = CW'(CAP_CYCLES - 1);
    localparam logic [MW-1:0] CNT_SAT   = MW'(CHAIN_LEN);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        DONE
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] pat_sr;
    logic [CHAIN_LEN-1:0] exp_sr;
    logic                 mis;
    logic [MW-1:0]        cnt_next;

    // Chain tail arrives MSB first, so the expected vector is consumed from the top.
    always_comb begin
        mis      = scan_out ^ exp_sr[CHAIN_LEN-1];
        cnt_next = mismatch_cnt;
        if (mis && (mismatch_cnt != CNT_SAT)) begin
            cnt_next = mismatch_cnt + MW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            pat_sr       <= '0;
            exp_sr       <= '0;
            scan_en      <= 1'b0;
            scan_in      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done    <= 1'b0;
                    scan_en <= 1'b0;
                    scan_in <= 1'b0;
                    if (start) begin
                        state        <= LOAD;
                        cnt          <= LOAD_LAST;
                        pat_sr       <= {pattern[CHAIN_LEN-2:0], 1'b0};
                        exp_sr       <= expected;
                        scan_en      <= 1'b1;
                        scan_in      <= pattern[CHAIN_LEN-1];
                        busy         <= 1'b1;
                        pass         <= 1'b0;
                        mismatch_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (cnt == '0) begin
                        state   <= CAPTURE;
                        cnt     <= CAP_LAST;
                        scan_en <= 1'b0;
                        scan_in <= 1'b0;
                    end else begin
                        cnt     <= cnt - CW'(1);
                        scan_in <= pat_sr[CHAIN_LEN-1];
                        pat_sr  <= {pat_sr[CHAIN_LEN-2:0], 1'b0};
                    end
                end
                CAPTURE: begin
                    if (cnt == '0) begin
                        state   <= UNLOAD;
                        cnt     <= LOAD_LAST;
                        scan_en <= 1'b1;
                        scan_in <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                UNLOAD: begin
                    mismatch_cnt <= cnt_next;
                    exp_sr       <= {exp_sr[CHAIN_LEN-2:0], 1'b0};
                    if (cnt == '0) begin
                        state   <= DONE;
                        scan_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (cnt_next == '0);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_test_controller.sv
// Directed bench: two controllers (CAP_CYCLES=1 and 3) each driving a
// model of a 4-bit scan-inserted up-counter.
module tb_scan_test_controller;

    logic       clk;
    logic       reset;

    logic       start0, start3;
    logic [3:0] pat0, pat3, exp0, exp3;
    logic       so0, so3;
    logic       en0, en3, sin0, sin3;
    logic       busy0, busy3, done0, done3, pass0, pass3;
    logic [2:0] mc0, mc3;
    logic [3:0] ch0, ch3;

    int tests = 0;
    int fails = 0;

    scan_test_controller #(.CHAIN_LEN(4), .CAP_CYCLES(1)) u0 (
        .clk(clk), .reset(reset), .start(start0),
        .pattern(pat0), .expected(exp0), .scan_out(so0),
        .scan_en(en0), .scan_in(sin0), .busy(busy0),
        .done(done0), .pass(pass0), .mismatch_cnt(mc0)
    );

    scan_test_controller #(.CHAIN_LEN(4), .CAP_CYCLES(3)) u3 (
        .clk(clk), .reset(reset), .start(start3),
        .pattern(pat3), .expected(exp3), .scan_out(so3),
        .scan_en(en3), .scan_in(sin3), .busy(busy3),
        .done(done3), .pass(pass3), .mismatch_cnt(mc3)
    );

    // Chain under test: flop i is counter bit i, flop 3 is the tail.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch0 <= '0;
            ch3 <= '0;
        end else begin
            ch0 <= en0 ? {ch0[2:0], sin0} : ch0 + 4'd1;
            ch3 <= en3 ? {ch3[2:0], sin3} : ch3 + 4'd1;
        end
    end

    assign so0 = ch0[3];
    assign so3 = ch3[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start3 = v;
        else     start0 = v;
    endtask

    task automatic run(input bit sel, input logic [3:0] p, input logic [3:0] e,
                       input bit hold, input bit poke,
                       output int lat, output logic [3:0] sseq,
                       output logic en_first, output logic en_cap,
                       output logic ps, output logic [2:0] mc);
        @(negedge clk);
        set_start(sel, 1'b1);
        if (sel) begin pat3 = p; exp3 = e; end
        else     begin pat0 = p; exp0 = e; end
        @(negedge clk);
        lat      = -1;
        sseq     = '0;
        ps       = 1'bx;
        mc       = 3'b111;
        en_first = sel ? en3 : en0;
        en_cap   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (!hold) set_start(sel, 1'b0);
            if (poke && (k == 2 || k == 7)) set_start(sel, 1'b1);
            if (k == 1 && !hold) begin
                if (sel) begin pat3 = ~p; exp3 = ~e; end
                else     begin pat0 = ~p; exp0 = ~e; end
            end
            if (k < 4) sseq[3-k] = sel ? sin3 : sin0;
            if (k == 4) en_cap = sel ? en3 : en0;
            if (sel ? done3 : done0) begin
                lat = k;
                ps  = sel ? pass3 : pass0;
                mc  = sel ? mc3 : mc0;
                break;
            end
            @(negedge clk);
        end
    endtask

    int         lat;
    logic [3:0] sseq;
    logic       enf, enc, ps;
    logic [2:0] mc;
    logic       seen;

    initial begin
        reset  = 1'b1;
        start0 = 1'b0; start3 = 1'b0;
        pat0 = '0; pat3 = '0; exp0 = '0; exp3 = '0;
        repeat (2) @(negedge clk);
        check("rst_scan_en", en0, 0);
        check("rst_scan_in", sin0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_mcnt", mc0, 0);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | en0 | en3;
        end
        check("idle_no_scan_en", seen, 0);

        // 5 -> 6 after one capture
        run(0, 4'b0101, 4'b0110, 0, 0, lat, sseq, enf, enc, ps, mc);
        check("dflt_latency", lat, 9);
        check("dflt_pass", ps, 1);
        check("dflt_mcnt", mc, 0);
        check("dflt_load_seq", sseq, 4'b0101);
        check("dflt_en_load", enf, 1);
        check("dflt_en_cap", enc, 0);
        @(negedge clk);
        check("dflt_done_1cyc", done0, 0);
        check("dflt_busy_off", busy0, 0);

        run(0, 4'b1111, 4'b0000, 0, 0, lat, sseq, enf, enc, ps, mc);
        check("wrap_latency", lat, 9);
        check("wrap_pass", ps, 1);
        check("wrap_load_seq", sseq, 4'b1111);
        @(negedge clk);

        // 14 + 3 captures = 17 -> 1
        run(1, 4'b1110, 4'b0001, 0, 0, lat, sseq, enf, enc, ps, mc);
        check("cap3_latency", lat, 11);
        check("cap3_pass", ps, 1);
        check("cap3_mcnt", mc, 0);
        check("cap3_load_seq", sseq, 4'b1110);
        @(negedge clk);

        run(0, 4'b0101, 4'b0111, 0, 0, lat, sseq, enf, enc, ps, mc);
        check("mis1_pass", ps, 0);
        check("mis1_mcnt", mc, 1);
        @(negedge clk);
        check("mis1_pass_held", pass0, 0);
        check("mis1_mcnt_held", mc0, 1);

        run(0, 4'b0101, 4'b1000, 0, 0, lat, sseq, enf, enc, ps, mc);
        check("mis3_pass", ps, 0);
        check("mis3_mcnt", mc, 3);
        @(negedge clk);

        run(0, 4'b0101, 4'b1001, 0, 0, lat, sseq, enf, enc, ps, mc);
        check("mis4_mcnt", mc, 4);
        @(negedge clk);

        // start pulses during LOAD and UNLOAD must be ignored
        run(0, 4'b0101, 4'b0111, 0, 1, lat, sseq, enf, enc, ps, mc);
        check("poke_latency", lat, 9);
        check("poke_mcnt", mc, 1);
        @(negedge clk);
        check("poke_idle1", busy0, 0);
        @(negedge clk);
        check("poke_idle2", busy0, 0);
        check("poke_mcnt_held", mc0, 1);

        // start held high: back-to-back, accepts 11 cycles apart
        run(0, 4'b0101, 4'b0110, 1, 0, lat, sseq, enf, enc, ps, mc);
        check("b2b_first_lat", lat, 9);
        check("b2b_first_pass", ps, 1);
        @(negedge clk);
        check("b2b_gap_idle", busy0, 0);
        @(negedge clk);
        check("b2b_reaccept", busy0, 1);
        start0 = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done0) begin lat = k; break; end
            @(negedge clk);
        end
        check("b2b_second_lat", lat, 9);
        check("b2b_second_pass", pass0, 1);
        @(negedge clk);

        // reset in UNLOAD abandons the test
        @(negedge clk);
        start0 = 1'b1; pat0 = 4'b0101; exp0 = 4'b0110;
        @(negedge clk);
        start0 = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_in_unload", en0, 1);
        reset = 1'b1;
        #1;
        check("abort_scan_en", en0, 0);
        check("abort_busy", busy0, 0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen = seen | done0 | busy0;
        end
        check("abort_no_done", seen, 0);

        run(0, 4'b0101, 4'b0110, 0, 0, lat, sseq, enf, enc, ps, mc);
        check("post_abort_lat", lat, 9);
        check("post_abort_pass", ps, 1);
        check("post_abort_mcnt", mc, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
